sha3_byte_packer: RTL

- Consumes the byte stream drained from syn_fifo (8-bit entries) and packs it into 64-bit little-endian Keccak lanes for the absorb stage.
- Reads exactly msg_len bytes per message, then appends SHA3 padding (0x06 ... 0x80) up to the rate boundary.
- Emits whole rate blocks lane by lane over a valid/ready interface.
- Sits between syn_fifo (upstream) and the Keccak-f absorb/permutation core (downstream).

---
 rtl/sha3_byte_packer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sha3_byte_packer.sv
// Packs the syn_fifo byte stream into little-endian 64-bit Keccak lanes and appends SHA3 padding
// up to the rate boundary. Lane outputs are registered; bytes are consumed only when the lane slot is free.
module sha3_byte_packer #(
  parameter int RATE_LANES = 17,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  output logic             busy,
  input  logic [7:0]       fifo_r_data,
  input  logic             fifo_empty,
  output logic             fifo_r_request,
  output logic [63:0]      lane_data,
  output logic [4:0]       lane_idx,
  output logic             lane_valid,
  input  logic             lane_ready,
  output logic             lane_last_block,
  output logic             lane_last,
  output logic             done
);

  localparam int CW = LEN_W + 1;
  localparam int RB = 8 * RATE_LANES;

  typedef enum logic [1:0] {IDLE, FETCH, PAD, DRAIN} state_t;

  state_t         state_q;
  logic [CW-1:0]  len_q, req_cnt_q, cap_cnt_q, blk_start_q;
  logic [2:0]     byte_pos_q;
  logic [4:0]     lane_cnt_q;
  logic [63:0]    asm_q, asm_d;
  logic           rd_pend_q, pad_first_q, busy_q, done_q;
  logic [63:0]    lane_data_q;
  logic [4:0]     lane_idx_q;
  logic           lane_valid_q, lane_last_block_q, lane_last_q;

  logic       out_free, pad_en, wr_en, blk_last_pos, cur_last_block, lane_wrap;
  logic [7:0] pad_byte, wr_byte;

  // A byte may only be produced when the output slot is free or draining this cycle.
  assign out_free       = !lane_valid_q || lane_ready;
  assign fifo_r_request = (state_q == FETCH) && !fifo_empty && (req_cnt_q < len_q) && out_free;
  assign pad_en         = (state_q == PAD) && out_free;
  assign wr_en          = rd_pend_q || pad_en;
  assign lane_wrap      = (lane_cnt_q == 5'(RATE_LANES - 1));
  assign blk_last_pos   = lane_wrap && (byte_pos_q == 3'd7);
  assign pad_byte       = (pad_first_q ? 8'h06 : 8'h00) | (blk_last_pos ? 8'h80 : 8'h00);
  assign wr_byte        = rd_pend_q ? fifo_r_data : pad_byte;
  // The current block holds the pad iff the message ends before this block's end.
  assign cur_last_block = (state_q == PAD) || ((len_q - blk_start_q) < CW'(RB));

  always_comb begin
    asm_d = asm_q;
    asm_d[{byte_pos_q, 3'b000} +: 8] = wr_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      len_q             <= '0;
      req_cnt_q         <= '0;
      cap_cnt_q         <= '0;
      blk_start_q       <= '0;
      byte_pos_q        <= '0;
      lane_cnt_q        <= '0;
      asm_q             <= '0;
      rd_pend_q         <= 1'b0;
      pad_first_q       <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      lane_data_q       <= '0;
      lane_idx_q        <= '0;
      lane_valid_q      <= 1'b0;
      lane_last_block_q <= 1'b0;
      lane_last_q       <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      rd_pend_q <= fifo_r_request;
      if (lane_valid_q && lane_ready) lane_valid_q <= 1'b0;
      if (fifo_r_request) req_cnt_q <= req_cnt_q + CW'(1);
      if (pad_en) pad_first_q <= 1'b0;

      if (wr_en) begin
        if (byte_pos_q == 3'd7) begin
          lane_data_q       <= asm_d;
          lane_idx_q        <= lane_cnt_q;
          lane_valid_q      <= 1'b1;
          lane_last_block_q <= cur_last_block;
          lane_last_q       <= cur_last_block && lane_wrap;
          asm_q             <= '0;
          byte_pos_q        <= '0;
          if (lane_wrap) begin
            lane_cnt_q  <= '0;
            blk_start_q <= blk_start_q + CW'(RB);
          end else begin
            lane_cnt_q <= lane_cnt_q + 5'd1;
          end
        end else begin
          asm_q      <= asm_d;
          byte_pos_q <= byte_pos_q + 3'd1;
        end
      end

      case (state_q)
        IDLE: if (start) begin
          len_q       <= {1'b0, msg_len};
          req_cnt_q   <= '0;
          cap_cnt_q   <= '0;
          blk_start_q <= '0;
          byte_pos_q  <= '0;
          lane_cnt_q  <= '0;
          asm_q       <= '0;
          pad_first_q <= 1'b1;
          busy_q      <= 1'b1;
          state_q     <= (msg_len == '0) ? PAD : FETCH;
        end
        FETCH: if (rd_pend_q) begin
          cap_cnt_q <= cap_cnt_q + CW'(1);
          if (cap_cnt_q + CW'(1) == len_q) state_q <= PAD;
        end
        PAD: if (pad_en && blk_last_pos) state_q <= DRAIN;
        DRAIN: if (lane_valid_q && lane_ready && lane_last_q) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign lane_data       = lane_data_q;
  assign lane_idx        = lane_idx_q;
  assign lane_valid      = lane_valid_q;
  assign lane_last_block = lane_last_block_q;
  assign lane_last       = lane_last_q;

endmodule
